// File: rtl/load_store_unit.sv
// Load/store unit: sizes, aligns and extends memory accesses over a
// simple req/ack bus, with misalignment faults and an ack timeout.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [1:0]  mem_type,
    input  logic        mem_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    localparam logic [1:0] MEM_BYTE     = 2'b00;
    localparam logic [1:0] MEM_HALFWORD = 2'b01;
    localparam logic [7:0] LAST         = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd_q, rd_d;
    logic [1:0]  type_q, type_d;
    logic        sgn_q, sgn_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
    logic [31:0] shifted;
    logic [15:0] half;
    logic        fault;
    logic        req;

    assign req   = mem_rd_en | mem_wr_en;
    assign fault = (mem_rd_en & mem_wr_en)
                 | ((mem_type == MEM_HALFWORD) & addr[0])
                 | (mem_type[1] & (addr[1:0] != 2'b00));

    // Lane steering uses only latched request fields
    always_comb begin
        shifted = bus_rdata >> {addr_q[1:0], 3'b000};
        half    = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        be      = 4'b1111;
        wd      = wdata_q;
        ld      = bus_rdata;
        unique case (1'b1)
            (type_q == MEM_BYTE): begin
                be = 4'b0001 << addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
                ld = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
            end
            (type_q == MEM_HALFWORD): begin
                be = 4'b0011 << {addr_q[1], 1'b0};
                wd = {2{wdata_q[15:0]}};
                ld = {{16{sgn_q & half[15]}}, half};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        type_d  = type_q;
        sgn_d   = sgn_q;
        we_d    = we_q;
        err_d   = err_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    stall   = 1'b1;
                    addr_d  = addr;
                    wdata_d = wr_data;
                    type_d  = mem_type;
                    sgn_d   = mem_signed;
                    we_d    = mem_wr_en;
                    err_d   = fault;
                    rd_d    = 32'h0;
                    cnt_d   = 8'h0;
                    state_d = fault ? DONE : REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_ack) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    rd_d    = we_q ? 32'h0 : ld;
                end else if (cnt_q == LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rd_d    = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rd_q    <= 32'h0;
            type_q  <= 2'b00;
            sgn_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            type_q  <= type_d;
            sgn_q   <= sgn_d;
            we_q    <= we_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_req   = (state_q == REQ);
    assign bus_we    = bus_req & we_q;
    assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_be    = bus_req ? be : 4'h0;
    assign bus_wdata = bus_req ? wd : 32'h0;
    assign done      = (state_q == DONE);
    assign err       = done & err_q;
    assign rd_data   = rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against an arithmetic
// reference model of sizing, lane selection and timeout rules.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [1:0]  mem_type;
    logic        mem_signed;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        stall;
    logic        done;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int n_cmp = 0;
    int n_err = 0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_type(mem_type), .mem_signed(mem_signed),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .stall(stall), .done(done), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_be(input logic [1:0] ty,
                                         input logic [31:0] a);
        if (ty == 2'd0) return 32'(1 << (a % 4));
        if (ty == 2'd1) return 32'(3 << (2 * ((a / 2) % 2)));
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] ty,
                                         input logic [31:0] d);
        if (ty == 2'd0) return (d & 32'hFF) * 32'h01010101;
        if (ty == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_ld(input logic [1:0] ty,
                                         input bit sg,
                                         input logic [31:0] a,
                                         input logic [31:0] r);
        logic [31:0] v;
        if (ty == 2'd0) begin
            v = (r >> (8 * (a % 4))) & 32'hFF;
            if (sg && v >= 32'd128) v = v - 32'd256;
        end else if (ty == 2'd1) begin
            v = (r >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (sg && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = r;
        end
        return v;
    endfunction

    task automatic run(input string nm, input bit rd, input bit wr,
                       input logic [1:0] ty, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdat, input int ackd,
                       input bit rstmid);
        bit flt;
        bit acked;
        bit eerr;
        int n;
        logic [31:0] erd;
        flt   = (rd && wr) || (ty == 2'd1 && a % 2 != 0)
              || (ty >= 2'd2 && a % 4 != 0);
        acked = ackd >= 1 && ackd <= TO;
        n     = acked ? ackd : TO;
        eerr  = flt || !acked;
        erd   = (eerr || wr) ? 32'h0 : m_ld(ty, sg, a, rdat);
        mem_rd_en  = rd;
        mem_wr_en  = wr;
        mem_type   = ty;
        mem_signed = sg;
        addr       = a;
        wr_data    = wd;
        bus_ack    = 1'b0;
        #1;
        chk({nm, "/stall0"}, stall, 1);
        chk({nm, "/req0"}, bus_req, 0);
        step();
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_type   = 2'($urandom);
        mem_signed = 1'($urandom);
        addr       = $urandom;
        wr_data    = $urandom;
        if (!flt) begin
            for (int k = 1; k <= n; k++) begin
                chk({nm, "/bus_req"}, bus_req, 1);
                chk({nm, "/stall"}, stall, 1);
                chk({nm, "/done_early"}, done, 0);
                chk({nm, "/bus_we"}, bus_we, wr);
                chk({nm, "/bus_addr"}, bus_addr, {a[31:2], 2'b00});
                chk({nm, "/bus_be"}, bus_be, m_be(ty, a));
                chk({nm, "/bus_wdata"}, bus_wdata, m_wd(ty, wd));
                bus_ack   = (k == ackd);
                bus_rdata = (k == ackd) ? rdat : $urandom;
                if (rstmid && k == 2) begin
                    rst = 1'b1;
                    step();
                    rst     = 1'b0;
                    bus_ack = 1'b0;
                    chk({nm, "/rst_req"}, bus_req, 0);
                    chk({nm, "/rst_done"}, done, 0);
                    chk({nm, "/rst_stall"}, stall, 0);
                    step();
                    chk({nm, "/rst_done2"}, done, 0);
                    chk({nm, "/rst_req2"}, bus_req, 0);
                    return;
                end
                step();
            end
        end
        bus_ack = 1'b0;
        chk({nm, "/done"}, done, 1);
        chk({nm, "/err"}, err, eerr);
        chk({nm, "/stall_d"}, stall, 0);
        chk({nm, "/req_d"}, bus_req, 0);
        chk({nm, "/rd_data"}, rd_data, erd);
        mem_rd_en = 1'b1;
        mem_type  = 2'd0;
        addr      = $urandom;
        bus_ack   = 1'b1;
        step();
        mem_rd_en = 1'b0;
        bus_ack   = 1'($urandom);
        #1;
        chk({nm, "/idle_done"}, done, 0);
        chk({nm, "/idle_stall"}, stall, 0);
        chk({nm, "/idle_req"}, bus_req, 0);
        step();
        bus_ack = 1'b0;
        chk({nm, "/idle_req2"}, bus_req, 0);
        chk({nm, "/idle_done2"}, done, 0);
    endtask

    initial begin
        rst        = 1'b1;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_type   = 2'd0;
        mem_signed = 1'b0;
        addr       = 32'h0;
        wr_data    = 32'h0;
        bus_rdata  = 32'h0;
        bus_ack    = 1'b0;
        step();
        step();
        chk("rst/stall", stall, 0);
        chk("rst/done", done, 0);
        chk("rst/err", err, 0);
        chk("rst/bus_req", bus_req, 0);
        chk("rst/bus_we", bus_we, 0);
        chk("rst/bus_be", bus_be, 0);
        chk("rst/bus_addr", bus_addr, 0);
        chk("rst/bus_wdata", bus_wdata, 0);
        chk("rst/rd_data", rd_data, 0);
        rst = 1'b0;
        step();

        run("lb_s", 1, 0, 2'd0, 1, 32'h1003, 32'h0, 32'h80FFFFFF, 2, 0);
        run("lhu", 1, 0, 2'd1, 0, 32'h2002, 32'h0, 32'h9ABC1234, 1, 0);
        run("sb", 0, 1, 2'd0, 0, 32'h11, 32'h123456A5, 32'hFFFFFFFF, 1, 0);
        run("lw_mis", 1, 0, 2'd2, 0, 32'h6, 32'h0, 32'h0, 1, 0);
        run("lw_to", 1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h5555AAAA, 0, 0);
        run("lw_last", 1, 0, 2'd3, 0, 32'h44, 32'h0, 32'hCAFEF00D, TO, 0);
        run("rst_mid", 1, 0, 2'd2, 0, 32'h80, 32'h0, 32'h1, 3, 1);
        run("after", 1, 0, 2'd1, 1, 32'h82, 32'h0, 32'h8001FFFF, 1, 0);
        run("both", 1, 1, 2'd0, 0, 32'h0, 32'h0, 32'h0, 1, 0);

        for (int i = 0; i < 300; i++) begin
            bit rd;
            bit wr;
            logic [31:0] a;
            int sel;
            sel = int'($urandom_range(0, 19));
            rd  = sel < 10 || sel == 19;
            wr  = !rd || sel == 19;
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run("rnd", rd, wr, 2'($urandom), 1'($urandom), a,
                $urandom, $urandom, int'($urandom_range(0, TO + 1)),
                $urandom_range(0, 24) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
